// File: rtl/gpio_pkg.sv
// Shared GPIO keypad definitions: matrix geometry, scan-state encoding and
// the priority encoder used to turn a key bitmap into a key code.
package gpio_pkg;

  localparam int KEY_ROWS   = 4;
  localparam int KEY_COLS   = 4;
  localparam int KEY_CODE_W = 4;
  localparam int KEY_MAP_W  = KEY_ROWS * KEY_COLS;

  typedef enum logic [1:0] {
    COL0 = 2'd0,
    COL1 = 2'd1,
    COL2 = 2'd2,
    COL3 = 2'd3
  } scan_state_t;

  // Lowest set index wins; an all-zero map encodes to 0.
  function automatic logic [KEY_CODE_W-1:0] lowest_key(input logic [KEY_MAP_W-1:0] map);
    logic [KEY_CODE_W-1:0] code;
    code = '0;
    for (int i = KEY_MAP_W - 1; i >= 0; i--) begin
      if (map[i]) code = KEY_CODE_W'(i);
    end
    return code;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Whole-map debouncer: a scanned map is committed once it has been seen on
// DEBOUNCE_SCANS+1 consecutive complete scans; any difference restarts the run.
module key_debounce
  import gpio_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [KEY_MAP_W-1:0] i_raw,
  input  logic                 i_scan_done,
  output logic [KEY_MAP_W-1:0] o_key_map,
  output logic                 o_key_down
);

  localparam logic [3:0] CNT_MAX = 4'(DEBOUNCE_SCANS);
  localparam logic [3:0] CNT_PRE = 4'(DEBOUNCE_SCANS - 1);

  logic [KEY_MAP_W-1:0] r_last_raw;
  logic [3:0]           r_stable_cnt;
  logic [KEY_MAP_W-1:0] r_key_map;
  logic                 r_key_down;

  logic w_same;
  logic w_commit;

  assign w_same   = (i_raw == r_last_raw);
  // Commit only on the transition into saturation so a held map is not re-committed.
  assign w_commit = i_scan_done && w_same && (r_stable_cnt == CNT_PRE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_raw   <= '0;
      r_stable_cnt <= '0;
    end else if (i_scan_done) begin
      if (w_same) begin
        if (r_stable_cnt != CNT_MAX) r_stable_cnt <= r_stable_cnt + 4'd1;
      end else begin
        r_last_raw   <= i_raw;
        r_stable_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_key_map  <= '0;
      r_key_down <= 1'b0;
    end else if (w_commit) begin
      r_key_map  <= i_raw;
      r_key_down <= |i_raw;
    end
  end

  assign o_key_map  = r_key_map;
  assign o_key_down = r_key_down;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner: column walk, row synchronizer, whole-map
// debounce, lowest-index press encoder and a ready/ack event handshake.
module keypad_scanner
  import gpio_pkg::*;
#(
  parameter int SCAN_DIV_BITS  = 16,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [KEY_ROWS-1:0]   row_in,
  output logic [KEY_COLS-1:0]   col_sel,
  output logic [KEY_MAP_W-1:0]  key_map,
  output logic                  key_down,
  output logic [KEY_CODE_W-1:0] key_code,
  output logic                  key_ready,
  output logic                  key_ovf,
  input  logic                  key_ack
);

  logic [KEY_ROWS-1:0]      r_row_meta;
  logic [KEY_ROWS-1:0]      r_row_sync;
  logic [SCAN_DIV_BITS-1:0] r_div;
  scan_state_t              r_state;
  scan_state_t              w_state_nxt;
  logic [KEY_COLS-1:0]      r_col_sel;
  logic [KEY_COLS-1:0]      w_col_sel_nxt;
  logic [KEY_MAP_W-1:0]     r_raw;
  logic [KEY_MAP_W-1:0]     w_raw_nxt;
  logic [KEY_MAP_W-1:0]     r_prev_map;
  logic [KEY_MAP_W-1:0]     w_key_map;
  logic [KEY_MAP_W-1:0]     w_new;
  logic                     w_key_down;
  logic [KEY_ROWS-1:0]      w_rows;
  logic [1:0]               w_col_idx;
  logic                     w_tick;
  logic                     w_scan_done;
  logic [KEY_CODE_W-1:0]    r_key_code;
  logic                     r_key_ready;
  logic                     r_key_ovf;

  // Sync flops idle high (no key) so reset does not look like a full press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_row_meta <= '1;
      r_row_sync <= '1;
    end else begin
      r_row_meta <= row_in;
      r_row_sync <= r_row_meta;
    end
  end

  assign w_rows = ~r_row_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_div <= '0;
    else     r_div <= r_div + 1'b1;
  end

  assign w_tick = &r_div;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= COL0;
      r_col_sel <= 4'b1110;
    end else begin
      r_state   <= w_state_nxt;
      r_col_sel <= w_col_sel_nxt;
    end
  end

  // col_sel is registered from the next state so the pad drive never glitches.
  always_comb begin
    w_state_nxt   = r_state;
    w_col_sel_nxt = 4'b1110;
    case (r_state)
      COL0:    if (w_tick) w_state_nxt = COL1;
      COL1:    if (w_tick) w_state_nxt = COL2;
      COL2:    if (w_tick) w_state_nxt = COL3;
      COL3:    if (w_tick) w_state_nxt = COL0;
      default: w_state_nxt = COL0;
    endcase
    case (w_state_nxt)
      COL0:    w_col_sel_nxt = 4'b1110;
      COL1:    w_col_sel_nxt = 4'b1101;
      COL2:    w_col_sel_nxt = 4'b1011;
      COL3:    w_col_sel_nxt = 4'b0111;
      default: w_col_sel_nxt = 4'b1110;
    endcase
  end

  assign w_col_idx   = r_state;
  assign w_scan_done = w_tick && (r_state == COL3);

  // The debouncer sees the merged map so the COL3 column captured this cycle counts.
  always_comb begin
    w_raw_nxt = r_raw;
    if (w_tick) w_raw_nxt[{w_col_idx, 2'b00} +: KEY_ROWS] = w_rows;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_raw <= '0;
    else     r_raw <= w_raw_nxt;
  end

  key_debounce #(
    .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
  ) u_debounce (
    .clk         (clk),
    .rst         (rst),
    .i_raw       (w_raw_nxt),
    .i_scan_done (w_scan_done),
    .o_key_map   (w_key_map),
    .o_key_down  (w_key_down)
  );

  // key_map only moves on commits, so new is nonzero exactly one cycle after a commit.
  assign w_new = w_key_map & ~r_prev_map;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_prev_map <= '0;
    else     r_prev_map <= w_key_map;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_key_code  <= '0;
      r_key_ready <= 1'b0;
      r_key_ovf   <= 1'b0;
    end else if (|w_new) begin
      r_key_code  <= lowest_key(w_new);
      r_key_ready <= 1'b1;
      r_key_ovf   <= ~key_ack & (r_key_ready | r_key_ovf);
    end else if (key_ack) begin
      r_key_ready <= 1'b0;
      r_key_ovf   <= 1'b0;
    end
  end

  assign col_sel   = r_col_sel;
  assign key_map   = w_key_map;
  assign key_down  = w_key_down;
  assign key_code  = r_key_code;
  assign key_ready = r_key_ready;
  assign key_ovf   = r_key_ovf;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a keypad emulator drives rows from col_sel; a
// scan-level model predicts commits from run lengths of identical scans.
module tb_keypad_scanner;

  localparam int SDB = 2;
  localparam int DBS = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  row_in;
  logic [3:0]  col_sel;
  logic [15:0] key_map;
  logic        key_down;
  logic [3:0]  key_code;
  logic        key_ready;
  logic        key_ovf;
  logic        key_ack = 1'b0;

  logic [15:0] phys = 16'h0;

  int checks   = 0;
  int failures = 0;

  logic [15:0] hist[$];
  logic [15:0] m_map;
  logic [3:0]  m_code;
  logic        m_ready;
  logic        m_ovf;

  keypad_scanner #(
    .SCAN_DIV_BITS  (SDB),
    .DEBOUNCE_SCANS (DBS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .row_in    (row_in),
    .col_sel   (col_sel),
    .key_map   (key_map),
    .key_down  (key_down),
    .key_code  (key_code),
    .key_ready (key_ready),
    .key_ovf   (key_ovf),
    .key_ack   (key_ack)
  );

  always #5 clk = ~clk;

  // Physical keypad: a held key pulls its row low while its column is driven.
  always @* begin
    row_in = 4'hF;
    for (int c = 0; c < 4; c++)
      if (col_sel[c] === 1'b0) row_in = ~phys[c*4 +: 4];
  end

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    hist.push_back(16'h0);
    m_map   = 16'h0;
    m_code  = 4'h0;
    m_ready = 1'b0;
    m_ovf   = 1'b0;
  endtask

  function automatic int run_len();
    int n = 0;
    for (int i = hist.size() - 1; i >= 0; i--) begin
      if (hist[i] != hist[hist.size() - 1]) break;
      n++;
    end
    return n;
  endfunction

  // Release reset and walk one full idle scan checking the column sequence;
  // returns one cycle into the second scan, aligned for scan().
  task automatic restart_and_walk();
    phys = 16'h0;
    rst  = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int p = 1; p <= 17; p++) begin
      @(posedge clk);
      #1;
      chk("col_walk", {12'h0, col_sel}, {12'h0, ~(4'b0001 << ((p / 4) % 4))});
    end
    model_reset();
    hist.push_back(16'h0);
  endtask

  // One 16-cycle scan with keys p held. ack_mode: 0 none, 1 mid-scan pulse,
  // 2 pulse in the cycle a committed press is encoded.
  task automatic scan(input logic [15:0] p, input int ack_mode);
    logic [15:0] newb;
    phys = p;
    repeat (7) @(posedge clk);
    #1;
    if (ack_mode == 1) key_ack = 1'b1;
    @(posedge clk);
    #1;
    key_ack = 1'b0;
    if (ack_mode == 1) begin
      m_ready = 1'b0;
      m_ovf   = 1'b0;
    end
    repeat (7) @(posedge clk);
    #1;
    if (ack_mode == 2) key_ack = 1'b1;
    @(posedge clk);
    #1;
    key_ack = 1'b0;

    hist.push_back(p);
    newb = 16'h0;
    if (run_len() == DBS + 1) begin
      newb  = p & ~m_map;
      m_map = p;
    end
    if (newb != 16'h0) begin
      for (int i = 0; i < 16; i++)
        if (newb[i]) begin
          m_code = 4'(i);
          break;
        end
      m_ovf   = (ack_mode == 2) ? 1'b0 : (m_ovf | m_ready);
      m_ready = 1'b1;
    end else if (ack_mode == 2) begin
      m_ready = 1'b0;
      m_ovf   = 1'b0;
    end

    chk("key_map",   key_map,            m_map);
    chk("key_down",  {15'h0, key_down},  {15'h0, |m_map});
    chk("key_code",  {12'h0, key_code},  {12'h0, m_code});
    chk("key_ready", {15'h0, key_ready}, {15'h0, m_ready});
    chk("key_ovf",   {15'h0, key_ovf},   {15'h0, m_ovf});
  endtask

  initial begin
    logic [15:0] rmap;
    int          hold;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_col_sel",   {12'h0, col_sel},   16'h000E);
    chk("rst_key_map",   key_map,            16'h0000);
    chk("rst_key_down",  {15'h0, key_down},  16'h0000);
    chk("rst_key_code",  {12'h0, key_code},  16'h0000);
    chk("rst_key_ready", {15'h0, key_ready}, 16'h0000);
    chk("rst_key_ovf",   {15'h0, key_ovf},   16'h0000);

    restart_and_walk();
    repeat (5) scan(16'h0, 0);

    // Clean press of col2,row2.
    repeat (3) scan(16'h0400, 0);
    chk("clean_pre_commit", key_map, 16'h0000);
    scan(16'h0400, 0);
    chk("clean_map",   key_map,             16'h0400);
    chk("clean_code",  {12'h0, key_code},   16'h000A);
    chk("clean_ready", {15'h0, key_ready},  16'h0001);
    scan(16'h0400, 0);

    // Release, then bounce for six scans before a steady hold.
    scan(16'h0, 1);
    repeat (3) scan(16'h0, 0);
    for (int i = 0; i < 6; i++) scan((i % 2 == 0) ? 16'h0400 : 16'h0000, 0);
    chk("bounce_no_commit", key_map, 16'h0000);
    repeat (3) scan(16'h0400, 0);
    chk("bounce_hold3", key_map, 16'h0000);
    scan(16'h0400, 0);
    chk("bounce_hold4", key_map, 16'h0400);

    // Overflow: key 1 unacknowledged, release, key 5.
    scan(16'h0, 1);
    repeat (3) scan(16'h0, 0);
    repeat (4) scan(16'h0002, 0);
    repeat (4) scan(16'h0, 0);
    repeat (4) scan(16'h0020, 0);
    chk("ovf_code", {12'h0, key_code}, 16'h0005);
    chk("ovf_flag", {15'h0, key_ovf},  16'h0001);
    scan(16'h0, 1);
    chk("ack_ready", {15'h0, key_ready}, 16'h0000);
    chk("ack_ovf",   {15'h0, key_ovf},   16'h0000);

    // Ack coinciding with a new press while a previous press is pending.
    repeat (3) scan(16'h0, 0);
    repeat (4) scan(16'h0004, 0);
    repeat (4) scan(16'h0, 0);
    repeat (3) scan(16'h0008, 0);
    scan(16'h0008, 2);
    chk("sim_ready", {15'h0, key_ready}, 16'h0001);
    chk("sim_code",  {12'h0, key_code},  16'h0003);
    chk("sim_ovf",   {15'h0, key_ovf},   16'h0000);

    // Two keys committed together, then released together.
    scan(16'h0, 1);
    repeat (3) scan(16'h0, 0);
    repeat (4) scan(16'h0210, 0);
    chk("multi_map",  key_map,            16'h0210);
    chk("multi_code", {12'h0, key_code},  16'h0004);
    scan(16'h0, 1);
    repeat (3) scan(16'h0, 0);
    chk("release_map",   key_map,            16'h0000);
    chk("release_down",  {15'h0, key_down},  16'h0000);
    chk("release_ready", {15'h0, key_ready}, 16'h0000);

    // Random holds of one or two keys with random acknowledge timing.
    for (int seg = 0; seg < 30; seg++) begin
      rmap = 16'h0;
      if ($urandom_range(0, 4) != 0) begin
        rmap = 16'h1 << $urandom_range(0, 15);
        if ($urandom_range(0, 2) == 0) rmap = rmap | (16'h1 << $urandom_range(0, 15));
      end
      hold = $urandom_range(1, 6);
      for (int k = 0; k < hold; k++) scan(rmap, $urandom_range(0, 2));
    end

    // Asynchronous reset mid-dwell, then a clean restart from COL0.
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_col_sel",   {12'h0, col_sel},   16'h000E);
    chk("mid_rst_key_map",   key_map,            16'h0000);
    chk("mid_rst_key_down",  {15'h0, key_down},  16'h0000);
    chk("mid_rst_key_code",  {12'h0, key_code},  16'h0000);
    chk("mid_rst_key_ready", {15'h0, key_ready}, 16'h0000);
    chk("mid_rst_key_ovf",   {15'h0, key_ovf},   16'h0000);
    restart_and_walk();
    repeat (4) scan(16'h8000, 0);
    chk("post_rst_code", {12'h0, key_code}, 16'h000F);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- GPIO input-side peripheral: scans a 4x4 active-low matrix keypad and debounces the whole key map.
- Delivers press events to the CPU bus glue as a latched key code with a ready/ack handshake.
- It is the input counterpart of the multiplexed seven-segment output driver.
- It sits in the GPIO subsystem beside that driver and shares its clock.

Parameters:
SCAN_DIV_BITS, 16, width of column dwell counter; one column is driven for 2^SCAN_DIV_BITS cycles.
DEBOUNCE_SCANS, 4, number of consecutive matching full scans, after the first, required to commit a key map; legal range 1..15.

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
row_in  input  4  keypad row lines, active-low, asynchronous to clk
col_sel  output  4  keypad column drive, active-low one-hot
key_map  output  16  debounced map; bit col*4+row is 1 when that key is held
key_down  output  1  OR-reduction of key_map
key_code  output  4  code of last newly pressed key (col*4+row)
key_ready  output  1  key_code holds an unacknowledged press
key_ovf  output  1  sticky flag: a press arrived while key_ready was already 1
key_ack  input  1  single-cycle acknowledge from bus glue

Behaviour:
- Reset values (async on rst=1): col_sel=4'b1110, key_map=0, key_down=0, key_code=0, key_ready=0, key_ovf=0. All internal counters and maps are 0.
- row_in passes through a 2-flop synchronizer. Rows are inverted to active-high before use.
- Dwell counter div (SCAN_DIV_BITS wide) free-runs. tick is high when div is all ones.
- Scan FSM has states COL0..COL3. col_sel is 1110, 1101, 1011, 0111 respectively.
- On tick, the synchronized rows are written into raw[col*4 +: 4]. The FSM advances COLn -> COL(n+1) mod 4 on the next edge.
- The scan-done strobe fires on the tick in COL3. raw is complete at that point, including the COL3 column written the same cycle.
- Debounce on scan-done:
  - If the complete raw equals last_raw, stable_cnt increments, saturating at DEBOUNCE_SCANS.
  - Otherwise last_raw takes raw and stable_cnt clears to 0.
  - When stable_cnt transitions to DEBOUNCE_SCANS, key_map takes raw (commit). A commit therefore needs DEBOUNCE_SCANS+1 identical consecutive scans.
  - Further identical scans do not re-commit.
- Press detection: on the cycle after a commit, new = key_map & ~prev_map. prev_map then updates to key_map.
  - If new is nonzero, the lowest set index is priority-encoded into key_code, and key_ready is set to 1.
  - If key_ready was already 1 and key_ack is low in that cycle, key_ovf is set to 1.
  - Releases (bits going 1->0) update key_map and key_down only. They produce no event.
- Handshake:
  - key_ack=1 clears key_ready and key_ovf on the next edge.
  - If key_ack coincides with a new press, the press wins: key_ready stays 1, key_code updates, and key_ovf is cleared rather than set.
  - key_ack while key_ready=0 has no effect.
- Multiple simultaneous new presses report only the lowest index. The others remain visible in key_map.
- Bounce mid-debounce restarts stable_cnt. key_map holds its last committed value.
- rst asserted mid-scan returns everything to reset values immediately. The scan restarts at COL0 with a full dwell.
- key_down is registered and updates in the same cycle as key_map.
- Latency for a clean press:
  - Up to one partial scan, plus (DEBOUNCE_SCANS+1) full scans of 4*2^SCAN_DIV_BITS cycles each, plus 2 cycles to key_ready.

Decomposition:
- Shared package gpio_pkg holds KEY_ROWS=4, KEY_COLS=4, KEY_CODE_W=4, and the scan-state enum COL0..COL3.
- One natural sub-module, key_debounce: takes the raw map and scan_done, and contains last_raw, stable_cnt and the commit logic. It outputs key_map.
- Scanner FSM, synchronizer, press encoder and handshake stay in the top module.

Test Plan (SCAN_DIV_BITS=2, DEBOUNCE_SCANS=3, so dwell is 4 cycles and a scan is 16 cycles):
- Reset/idle: assert rst mid-run, release, rows=4'hF -> col_sel=1110, then 1101/1011/0111 each held 4 cycles. Outputs stay 0 indefinitely.
- Clean press: row 2 low only while col_sel=1011 (key col2,row2) -> key_map=16'h0400 within 5 scans; key_down=1; key_code=4'hA; key_ready=1 two cycles after commit.
- Bounce: toggle that key every other scan for 6 scans, then hold -> no commit during toggling. Commit occurs exactly 4 scans into the steady hold.
- Overflow/ack: press key 1, no ack, release, then press key 5 -> key_code=5, key_ovf=1. Pulse key_ack -> key_ready=0, key_ovf=0.
- Simultaneous: ack in the same cycle as a new press of key 3 -> key_ready=1, key_code=3, key_ovf=0.
- Multi-press: keys 9 and 4 committed together -> key_map=16'h0210, key_code=4. Releasing both gives key_map=0, key_down=0, no new event.
